instr_enc: RTL and testbench
============================

# instr_enc

RV32I instruction encoder: the write-side counterpart of the opcode decoder. It accepts decoded instruction fields (format, opcode, register indices, funct fields, immediate) over a valid/ready handshake. It packs them into 32-bit instruction words, legality-checks them, tags each word with a sequential instruction-memory word address, and buffers results in a 2-entry output FIFO. It sits between the test/program-generation front end and the instruction-memory loader.

## Interface

Parameters:
- `ADDR_W`, 8, width of the instruction-memory word address.
- `BASE_ADDR`, 0, address assigned after reset or `pc_clear`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: field bundle valid.
- `in_ready` output 1: encoder can accept.
- `fmt` input 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6–7 illegal.
- `opcode` input 7: major opcode.
- `rd`, `rs1`, `rs2` input 5 each: register indices.
- `funct3` input 3; `funct7` input 7.
- `imm` input 32: sign-extended immediate (U: full value, low 12 bits must be 0).
- `pc_clear` input 1: synchronous restart of the address counter and clear of `err_seen`.
- `out_valid` output 1; `out_ready` input 1: output handshake.
- `out_instr` output 32: encoded word.
- `out_addr` output ADDR_W: word address of `out_instr`.
- `out_err` output 1: entry was illegal (word replaced by NOP).
- `err_seen` output 1: sticky, set by any accepted illegal entry.

## Operation

- Encoding is combinational on the input fields and is written into the FIFO on an input handshake (`in_valid && in_ready`).
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Legality: the entry is illegal if any of the following holds.
  - `fmt` is greater than 5.
  - The opcode does not match the format:
    - R: 0110011.
    - I: 0010011, 0000011, 1100111 or 1110011.
    - S: 0100011.
    - B: 1100011.
    - U: 0110111 or 0010111.
    - J: 1101111.
  - The immediate is out of range:
    - I/S: imm[31:11] are not all equal.
    - B: imm[31:12] are not all equal, or imm[0] is 1.
    - J: imm[31:20] are not all equal, or imm[0] is 1.
    - U: imm[11:0] is not 0.
- Illegal entries are still enqueued, with `out_instr`=0x00000013 (NOP) and `out_err`=1.
- The address counter is assigned at push: each pushed entry stores the current counter value, then the counter increments modulo 2^ADDR_W (wraps silently).
- The FIFO has 2 entries; occupancy 0/1/2 is the block's state (EMPTY/ONE/FULL).
  - EMPTY→ONE on push.
  - ONE→FULL on push without pop.
  - ONE→EMPTY on pop without push.
  - ONE holds on simultaneous push and pop.
  - FULL→ONE on pop.
- Outputs are driven from the head entry.

## Timing

- `in_ready` = occupancy < 2, registered-state derived; it does not depend on `out_ready`, so there is no combinational path from `out_ready` to `in_ready`.
- Latency: a word accepted at edge N is presented with `out_valid`=1 after edge N (visible in cycle N+1). There is no bypass.
- `out_valid`, `out_instr`, `out_addr` and `out_err` are held stable while `out_valid && !out_ready`.
- When FULL, a push is refused even if a pop occurs in the same cycle.
- `pc_clear`:
  - When asserted without a push, the counter becomes BASE_ADDR.
  - When asserted with a push, the pushed entry gets BASE_ADDR and the counter becomes BASE_ADDR+1.
  - `err_seen` is cleared, unless the same-cycle push is illegal, in which case it is set.
  - FIFO contents are untouched.
- Reset (`rst`=0, at any time, including mid-transfer):
  - Occupancy becomes 0, so `out_valid`=0 and `in_ready`=1 on the first cycle after release.
  - Counter = BASE_ADDR; `err_seen`=0.
  - `out_instr`=0, `out_addr`=0, `out_err`=0.
  - In-flight entries are discarded.

## Structure

- Shared package `rv_pkg`:
  - Format encodings (FMT_R..FMT_J).
  - Opcode constants (OP_REG, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL).
  - NOP constant 0x00000013.
  - These are shared with the decoder.
- One sub-module, `instr_enc_fifo`: a 2-entry FIFO of {illegal flag, address, word}. The packing and legality logic stays in `instr_enc`.

## Test plan

- Legal encodings, one push each, with `out_ready`=1:
  - I addi x1,x0,5 (opcode 0010011, imm 5) → 0x00500093.
  - R add x3,x1,x2 (opcode 0110011) → 0x002081B3.
  - S sw x2,8(x1) (funct3 010) → 0x0020A423.
  - B beq x0,x0,imm=-4 → 0xFE000EE3.
  - U lui x5, imm 0x12345000 → 0x123452B7.
  - Check `out_addr` for these five pushes is 0,1,2,3,4.
- Backpressure: hold `out_ready`=0 and push 3 entries → `in_ready`=0 after the 2nd; the head stays stable. Release → entries drain in order and the 3rd is accepted.
- Illegal entries:
  - I with imm=2048 → `out_instr`=0x00000013, `out_err`=1, `err_seen`=1.
  - B with imm=3 → `out_err`=1.
  - `pc_clear` → `err_seen`=0.
- Wrap: with ADDR_W=2, push 5 → `out_addr` sequence 0,1,2,3,0.
- Simultaneous events:
  - Push and pop in ONE → occupancy stays 1.
  - `pc_clear` with a push → that entry has address BASE_ADDR and the next push has BASE_ADDR+1.
- Reset mid-operation: reset while FULL → `out_valid`=0 and `in_ready`=1 after release; the next push has `out_addr`=BASE_ADDR.

Source files
------------

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg: RV32I constants shared by the instruction decoder and encoder.
//   - fmt_e        : instruction format codes carried on the 3-bit fmt field
//   - OP_*         : major opcode constants
//   - NOP_INSTR    : canonical NOP (addi x0,x0,0), used to replace illegal words
//   - fifo_state_e : occupancy state of the encoder's 2-entry output FIFO
// ---------------------------------------------------------------------------
package rv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/instr_enc_fifo.sv
// ---------------------------------------------------------------------------
// instr_enc_fifo: 2-entry FIFO holding encoded {illegal, address, word} entries.
// Occupancy is the FSM state (EMPTY/ONE/FULL) and is exported for observation.
//
// Handshake: a push is taken when push_i && in_ready_o; a pop is taken when
// pop_i && out_valid_o. in_ready_o and out_valid_o are decoded from the state
// register only, so neither depends combinationally on push_i or pop_i. A push
// offered while FULL is refused even if a pop happens in the same cycle.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write request and entry
//   pop_i           consume the head entry
//   in_ready_o      space available (state != FULL)
//   out_valid_o     head entry valid (state != EMPTY)
//   data_o          head entry (all zero after reset)
//   state_o         current occupancy state
// ---------------------------------------------------------------------------
module instr_enc_fifo
    import rv_pkg::*;
#(
    parameter int W = 41
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         in_ready_o,
    output logic         out_valid_o,
    output logic [W-1:0] data_o,
    output fifo_state_e  state_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    fifo_state_e  state_q;

    logic push_ok;
    logic pop_ok;

    assign in_ready_o  = (state_q != FIFO_FULL);
    assign out_valid_o = (state_q != FIFO_EMPTY);
    assign push_ok     = push_i && in_ready_o;
    assign pop_ok      = pop_i && out_valid_o;

    // Head is read from the storage slot; a push while ONE writes the other
    // slot, so the presented entry never changes until it is popped.
    assign data_o  = mem_q[rd_ptr_q];
    assign state_o = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            state_q  <= FIFO_EMPTY;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case (state_q)
                FIFO_EMPTY: if (push_ok) state_q <= FIFO_ONE;
                FIFO_ONE: begin
                    if (push_ok && !pop_ok)      state_q <= FIFO_FULL;
                    else if (pop_ok && !push_ok) state_q <= FIFO_EMPTY;
                end
                FIFO_FULL:  if (pop_ok) state_q <= FIFO_ONE;
                default:    state_q <= FIFO_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/instr_enc.sv
// ---------------------------------------------------------------------------
// instr_enc: RV32I instruction encoder. Packs decoded fields into a 32-bit
// word, checks legality, tags the word with a sequential instruction-memory
// word address and queues it in a 2-entry output FIFO.
//
// Handshake: input transfer on in_valid && in_ready, output transfer on
// out_valid && out_ready. in_ready is derived from registered occupancy only
// (no path from out_ready). Output fields are held while out_valid && !out_ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid / in_ready      field bundle handshake
//   fmt, opcode, rd, rs1, rs2, funct3, funct7, imm   decoded fields
//   pc_clear                 synchronous restart of address counter, clears err_seen
//   out_valid / out_ready    output handshake
//   out_instr, out_addr      encoded word and its word address
//   out_err                  entry was illegal (word replaced by NOP)
//   err_seen                 sticky flag for any accepted illegal entry
//   dbg_state                FIFO occupancy state
// ---------------------------------------------------------------------------
module instr_enc
    import rv_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              pc_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_seen,
    output fifo_state_e       dbg_state
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam int                EW   = ADDR_W + 33;

    // ------------------------------------------------------------------
    // Packing and legality
    // ------------------------------------------------------------------
    logic [31:0] word_raw;
    logic        fmt_ok;
    logic        op_ok;
    logic        imm_ok;
    logic        illegal;

    always_comb begin
        word_raw = '0;
        fmt_ok   = 1'b1;
        op_ok    = 1'b0;
        imm_ok   = 1'b0;
        case (fmt)
            FMT_R: begin
                word_raw = {funct7, rs2, rs1, funct3, rd, opcode};
                op_ok    = (opcode == OP_REG);
                imm_ok   = 1'b1;
            end
            FMT_I: begin
                word_raw = {imm[11:0], rs1, funct3, rd, opcode};
                op_ok    = (opcode == OP_IMM) || (opcode == OP_LOAD) ||
                           (opcode == OP_JALR) || (opcode == OP_SYSTEM);
                // 12-bit signed: everything above bit 11 must copy bit 11
                imm_ok   = (&imm[31:11]) || !(|imm[31:11]);
            end
            FMT_S: begin
                word_raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                op_ok    = (opcode == OP_STORE);
                imm_ok   = (&imm[31:11]) || !(|imm[31:11]);
            end
            FMT_B: begin
                word_raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                op_ok    = (opcode == OP_BRANCH);
                // 13-bit signed, halfword aligned
                imm_ok   = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            end
            FMT_U: begin
                word_raw = {imm[31:12], rd, opcode};
                op_ok    = (opcode == OP_LUI) || (opcode == OP_AUIPC);
                imm_ok   = (imm[11:0] == 12'h000);
            end
            FMT_J: begin
                word_raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                op_ok    = (opcode == OP_JAL);
                // 21-bit signed, halfword aligned
                imm_ok   = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            end
            default: begin
                fmt_ok = 1'b0;
            end
        endcase
        illegal = !(fmt_ok && op_ok && imm_ok);
    end

    // ------------------------------------------------------------------
    // Address counter and sticky error
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_seen_q, err_seen_d;
    logic [ADDR_W-1:0] push_addr;
    logic              push;

    assign push      = in_valid && in_ready;
    // A same-cycle pc_clear restarts numbering with the entry being pushed.
    assign push_addr = pc_clear ? BASE : addr_q;

    always_comb begin
        addr_d = addr_q;
        if (push)          addr_d = push_addr + ADDR_W'(1);
        else if (pc_clear) addr_d = BASE;

        // pc_clear wins over the old value, but an illegal entry pushed in
        // the same cycle still registers as seen.
        if (pc_clear) err_seen_d = push && illegal;
        else          err_seen_d = err_seen_q || (push && illegal);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= BASE;
            err_seen_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            err_seen_q <= err_seen_d;
        end
    end

    assign err_seen = err_seen_q;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head_entry;

    assign push_entry = {illegal, push_addr, (illegal ? NOP_INSTR : word_raw)};

    instr_enc_fifo #(
        .W (EW)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (in_valid),
        .data_i      (push_entry),
        .pop_i       (out_ready),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .data_o      (head_entry),
        .state_o     (dbg_state)
    );

    assign {out_err, out_addr, out_instr} = head_entry;

endmodule

// File: tb/tb_instr_enc.sv
module tb_instr_enc;
    import rv_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid_w;
    logic        in_ready, in_ready_w;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        pc_clear;
    logic        out_valid, out_valid_w;
    logic        out_ready, out_ready_w;
    logic [31:0] out_instr, out_instr_w;
    logic [7:0]  out_addr;
    logic [1:0]  out_addr_w;
    logic        out_err, out_err_w;
    logic        err_seen, err_seen_w;
    fifo_state_e dbg_state, dbg_state_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_enc #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .pc_clear(pc_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_seen(err_seen),
        .dbg_state(dbg_state)
    );

    // Narrow-address instance for the counter wrap scenario
    instr_enc #(.ADDR_W(2), .BASE_ADDR(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .pc_clear(pc_clear),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_instr(out_instr_w),
        .out_addr(out_addr_w), .out_err(out_err_w), .err_seen(err_seen_w),
        .dbg_state(dbg_state_w)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic drive_addi(input logic [4:0] d, input logic [31:0] im);
        drive(FMT_I, OP_IMM, d, 5'd0, 5'd0, 3'd0, 7'd0, im);
    endtask

    task automatic push_one();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b exp 1", in_ready); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset out_instr: got %h exp 00000000", out_instr); end
        checks++; if (out_addr !== 8'h0) begin errors++; $display("FAIL reset out_addr: got %h exp 00", out_addr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset out_err: got %b exp 0", out_err); end
        checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL reset err_seen: got %b exp 0", err_seen); end
        checks++; if (dbg_state !== FIFO_EMPTY) begin errors++; $display("FAIL reset state: got %0d exp 0", dbg_state); end
    endtask

    task automatic test_legal();
        logic [2:0]  f  [6] = '{FMT_I, FMT_R, FMT_S, FMT_B, FMT_U, FMT_J};
        logic [6:0]  op [6] = '{OP_IMM, OP_REG, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL};
        logic [4:0]  d  [6] = '{5'd1, 5'd3, 5'd0, 5'd0, 5'd5, 5'd0};
        logic [4:0]  s1 [6] = '{5'd0, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0};
        logic [4:0]  s2 [6] = '{5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0};
        logic [2:0]  f3 [6] = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
        logic [31:0] im [6] = '{32'd5, 32'd0, 32'd8, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0800};
        logic [31:0] ex [6] = '{32'h0050_0093, 32'h0020_81B3, 32'h0020_A423,
                                32'hFE00_0EE3, 32'h1234_52B7, 32'h0010_006F};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(f[i], op[i], d[i], s1[i], s2[i], f3[i], 7'd0, im[i]);
            push_one();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL legal[%0d] out_valid: got %b exp 1", i, out_valid); end
            checks++; if (out_instr !== ex[i]) begin errors++; $display("FAIL legal[%0d] out_instr: got %h exp %h", i, out_instr, ex[i]); end
            checks++; if (out_addr !== 8'(i)) begin errors++; $display("FAIL legal[%0d] out_addr: got %0d exp %0d", i, out_addr, i); end
            checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL legal[%0d] out_err: got %b exp 0", i, out_err); end
        end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL legal drain out_valid: got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive_addi(5'd1, 32'd1);
        push_one();
        drive_addi(5'd2, 32'd2);
        push_one();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready full: got %b exp 0", in_ready); end
        checks++; if (dbg_state !== FIFO_FULL) begin errors++; $display("FAIL bp state full: got %0d exp 2", dbg_state); end
        // Offer a third entry while full: it must be refused and the head held.
        drive_addi(5'd3, 32'd3);
        push_one();
        checks++; if (out_instr !== 32'h0010_0093) begin errors++; $display("FAIL bp head instr held: got %h exp 00100093", out_instr); end
        checks++; if (out_addr !== 8'd6) begin errors++; $display("FAIL bp head addr held: got %0d exp 6", out_addr); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp out_valid held: got %b exp 1", out_valid); end
        // Release: pop while full refuses the same-cycle push.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (dbg_state !== FIFO_ONE) begin errors++; $display("FAIL bp pop-full state: got %0d exp 1", dbg_state); end
        checks++; if (out_instr !== 32'h0020_0113) begin errors++; $display("FAIL bp second instr: got %h exp 00200113", out_instr); end
        checks++; if (out_addr !== 8'd7) begin errors++; $display("FAIL bp second addr: got %0d exp 7", out_addr); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_instr !== 32'h0030_0193) begin errors++; $display("FAIL bp third instr: got %h exp 00300193", out_instr); end
        checks++; if (out_addr !== 8'd8) begin errors++; $display("FAIL bp third addr: got %0d exp 8", out_addr); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp drained out_valid: got %b exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive_addi(5'd1, 32'd2048);
        push_one();
        checks++; if (out_instr !== 32'h0000_0013) begin errors++; $display("FAIL ill i2048 instr: got %h exp 00000013", out_instr); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL ill i2048 out_err: got %b exp 1", out_err); end
        checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL ill i2048 err_seen: got %b exp 1", err_seen); end
        checks++; if (out_addr !== 8'd9) begin errors++; $display("FAIL ill i2048 addr: got %0d exp 9", out_addr); end
        drive(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        push_one();
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL ill b_odd out_err: got %b exp 1", out_err); end
        checks++; if (out_instr !== 32'h0000_0013) begin errors++; $display("FAIL ill b_odd instr: got %h exp 00000013", out_instr); end
        drive(3'd6, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        push_one();
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL ill fmt6 out_err: got %b exp 1", out_err); end
        drive(FMT_R, OP_IMM, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        push_one();
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL ill r_badop out_err: got %b exp 1", out_err); end
        drive(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        push_one();
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL ill u_low out_err: got %b exp 1", out_err); end
        // Most negative 12-bit immediate is still legal
        drive_addi(5'd1, 32'hFFFF_F800);
        push_one();
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL ill i_min out_err: got %b exp 0", out_err); end
        checks++; if (out_instr !== 32'h8000_0093) begin errors++; $display("FAIL ill i_min instr: got %h exp 80000093", out_instr); end
        tick();
        checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL ill sticky err_seen: got %b exp 1", err_seen); end
        pc_clear = 1'b1;
        tick();
        pc_clear = 1'b0;
        checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL ill pc_clear err_seen: got %b exp 0", err_seen); end
    endtask

    task automatic test_pc_clear_push();
        out_ready = 1'b1;
        drive_addi(5'd1, 32'd1);
        push_one();
        checks++; if (out_addr !== 8'd0) begin errors++; $display("FAIL pcc first addr: got %0d exp 0", out_addr); end
        drive_addi(5'd1, 32'd4096);
        push_one();
        checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL pcc illegal err_seen: got %b exp 1", err_seen); end
        checks++; if (out_addr !== 8'd1) begin errors++; $display("FAIL pcc second addr: got %0d exp 1", out_addr); end
        drive_addi(5'd2, 32'd2);
        pc_clear = 1'b1;
        push_one();
        pc_clear = 1'b0;
        checks++; if (out_addr !== 8'd0) begin errors++; $display("FAIL pcc push addr: got %0d exp 0", out_addr); end
        checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL pcc legal push err_seen: got %b exp 0", err_seen); end
        push_one();
        checks++; if (out_addr !== 8'd1) begin errors++; $display("FAIL pcc next addr: got %0d exp 1", out_addr); end
        drive_addi(5'd2, 32'hFFFF_F000);
        pc_clear = 1'b1;
        push_one();
        pc_clear = 1'b0;
        checks++; if (out_addr !== 8'd0) begin errors++; $display("FAIL pcc ill push addr: got %0d exp 0", out_addr); end
        checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL pcc ill push err_seen: got %b exp 1", err_seen); end
        checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL pcc ill push out_err: got %b exp 1", out_err); end
        tick();
    endtask

    task automatic test_push_pop_one();
        out_ready = 1'b1;
        drive_addi(5'd1, 32'd1);
        push_one();
        checks++; if (dbg_state !== FIFO_ONE) begin errors++; $display("FAIL pp state after push: got %0d exp 1", dbg_state); end
        drive_addi(5'd2, 32'd2);
        push_one();
        checks++; if (dbg_state !== FIFO_ONE) begin errors++; $display("FAIL pp state push+pop: got %0d exp 1", dbg_state); end
        checks++; if (out_instr !== 32'h0020_0113) begin errors++; $display("FAIL pp head instr: got %h exp 00200113", out_instr); end
        checks++; if (out_addr !== 8'd2) begin errors++; $display("FAIL pp head addr: got %0d exp 2", out_addr); end
        tick();
        checks++; if (dbg_state !== FIFO_EMPTY) begin errors++; $display("FAIL pp state drained: got %0d exp 0", dbg_state); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_addr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        out_ready_w = 1'b1;
        drive_addi(5'd1, 32'd5);
        in_valid_w = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_addr_w !== exp_addr[i]) begin errors++; $display("FAIL wrap[%0d] addr: got %0d exp %0d", i, out_addr_w, exp_addr[i]); end
        end
        in_valid_w = 1'b0;
        checks++; if (out_valid_w !== 1'b1) begin errors++; $display("FAIL wrap out_valid: got %b exp 1", out_valid_w); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_addi(5'd1, 32'd2048);
        push_one();
        drive_addi(5'd1, 32'd1);
        push_one();
        checks++; if (dbg_state !== FIFO_FULL) begin errors++; $display("FAIL rmid state before: got %0d exp 2", dbg_state); end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid async out_valid: got %b exp 0", out_valid); end
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid out_valid: got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid in_ready: got %b exp 1", in_ready); end
        checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL rmid err_seen: got %b exp 0", err_seen); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rmid out_instr: got %h exp 00000000", out_instr); end
        out_ready = 1'b1;
        drive_addi(5'd3, 32'd3);
        push_one();
        checks++; if (out_addr !== 8'd0) begin errors++; $display("FAIL rmid next addr: got %0d exp 0", out_addr); end
        checks++; if (out_instr !== 32'h0030_0193) begin errors++; $display("FAIL rmid next instr: got %h exp 00300193", out_instr); end
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        in_valid    = 1'b0;
        in_valid_w  = 1'b0;
        out_ready   = 1'b0;
        out_ready_w = 1'b0;
        pc_clear    = 1'b0;
        drive(FMT_I, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        test_reset();
        test_legal();
        test_backpressure();
        test_illegal();
        test_pc_clear_push();
        test_push_pop_one();
        test_wrap();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
